// File: rtl/custom_instruction_sequencer.sv
// Custom-instruction sequencer: issues a one-cycle start to one of four units and
// stalls the execute stage until that unit's done arrives (N+1 cycles for done at N).
// Backpressure: ciStall holds the pipeline in WAIT; HOLD absorbs external pipelineStall.
// Optional watchdog: define CI_WATCHDOG_EN to abort a unit hung in WAIT.
module custom_instruction_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic         cpuClock,
  input  logic         cpuReset,
  input  logic         exeCustom,
  input  logic [1:0]   exeCiUnit,
  input  logic [7:0]   exeCiN,
  input  logic         pipelineStall,
  output logic         ciStall,
  output logic [3:0]   ciStart,
  output logic [7:0]   ciValueN,
  input  logic [3:0]   ciDone,
  input  logic [127:0] ciResultBus,
  output logic [31:0]  customInstructionResult,
  output logic         customInstructionDone,
  output logic         ciTimeout
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t      state;
  state_t      next_state;
  logic [1:0]  locked_unit;
  logic [1:0]  active_unit;
  logic        sel_done;
  logic [31:0] sel_result;
  logic        wd_expired;

  // In IDLE the unit comes straight from the instruction so zero-latency units can finish at once.
  assign active_unit = (state == IDLE) ? exeCiUnit : locked_unit;
  assign sel_done    = ciDone[active_unit];
  assign sel_result  = ciResultBus[{active_unit, 5'b00000} +: 32];

`ifdef CI_WATCHDOG_EN
  logic [TIMEOUT_WIDTH-1:0] wd_count;

  assign wd_expired = (state == WAIT) &&
                      (wd_count == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

  // Watchdog counts WAIT cycles; held at zero outside WAIT so it is clear on entry.
  always_ff @(posedge cpuClock) begin
    if (cpuReset) begin
      wd_count <= '0;
    end else if (state != WAIT) begin
      wd_count <= '0;
    end else begin
      wd_count <= wd_count + 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign wd_expired = 1'b0;
  assign unused_cfg = (TIMEOUT_CYCLES > 0) && (TIMEOUT_WIDTH > 0);
`endif

  // State register and the unit captured at issue time.
  always_ff @(posedge cpuClock) begin
    if (cpuReset) begin
      state       <= IDLE;
      locked_unit <= 2'd0;
    end else begin
      state <= next_state;
      if (state == IDLE && exeCustom) begin
        locked_unit <= exeCiUnit;
      end
    end
  end

  // Next-state and output decode; reset overrides everything so outputs read zero.
  always_comb begin
    next_state              = state;
    ciStall                 = 1'b0;
    ciStart                 = 4'b0000;
    ciValueN                = 8'h00;
    customInstructionResult = 32'h0;
    customInstructionDone   = 1'b0;
    ciTimeout               = 1'b0;

    case (state)
      IDLE: begin
        if (exeCustom) begin
          ciStart  = 4'b0001 << exeCiUnit;
          ciValueN = exeCiN;
          if (sel_done) begin
            customInstructionDone   = 1'b1;
            customInstructionResult = sel_result;
            next_state              = pipelineStall ? HOLD : IDLE;
          end else begin
            ciStall    = 1'b1;
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        // A real done beats a watchdog expiry in the same cycle.
        if (sel_done) begin
          customInstructionDone   = 1'b1;
          customInstructionResult = sel_result;
          next_state              = pipelineStall ? HOLD : IDLE;
        end else if (wd_expired) begin
          ciTimeout             = 1'b1;
          customInstructionDone = 1'b1;
          next_state            = pipelineStall ? HOLD : IDLE;
        end else begin
          ciStall = 1'b1;
        end
      end
      HOLD: begin
        // Result already latched by the execute stage; just wait out the external stall.
        if (!pipelineStall) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase

    if (cpuReset) begin
      next_state              = IDLE;
      ciStall                 = 1'b0;
      ciStart                 = 4'b0000;
      ciValueN                = 8'h00;
      customInstructionResult = 32'h0;
      customInstructionDone   = 1'b0;
      ciTimeout               = 1'b0;
    end
  end

endmodule
